// File: rtl/adder_subtractor.sv
// -----------------------------------------------------------------------------
// adder_subtractor
//   Two's-complement ripple-carry adder/subtractor with a zero-latency
//   combinational result and a one-cycle registered copy carrying status flags.
//
// Ports
//   clk       : system clock, registers update on the rising edge
//   rst_n     : asynchronous active-low reset (registered outputs only)
//   A, B      : WIDTH-bit operands (unsigned or two's complement)
//   M         : mode, 0 = A+B, 1 = A-B
//   in_valid  : qualifies A/B/M for capture into the output register
//   result    : combinational {carry_out, sum}
//   result_q  : registered result
//   out_valid : result_q/flags_q hold a capture made on the previous edge
//   flags_q   : registered {overflow, negative, zero, carry}
// -----------------------------------------------------------------------------
module adder_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  input  logic             in_valid,
  output logic [WIDTH:0]   result,
  output logic [WIDTH:0]   result_q,
  output logic             out_valid,
  output logic [3:0]       flags_q
);

  // Pack the status flags in {overflow, negative, zero, carry} order.
  function automatic logic [3:0] pack_flags(
    input logic [WIDTH-1:0] s,
    input logic             c_msb_in,
    input logic             c_out
  );
    logic ovf;
    logic neg;
    logic zro;
    // Signed overflow: carry into the MSB disagrees with carry out of it.
    ovf = c_msb_in ^ c_out;
    neg = s[WIDTH-1];
    zro = (s == '0);
    return {ovf, neg, zro, c_out};
  endfunction

  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic [3:0]       flags;

  // Ripple chain: subtract is A + ~B + 1, with the +1 entering as carry-in.
  always_comb begin
    b_x      = B ^ {WIDTH{M}};
    carry    = '0;
    sum      = '0;
    carry[0] = M;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]     = A[i] ^ b_x[i] ^ carry[i];
      carry[i+1] = (A[i] & b_x[i]) | (carry[i] & (A[i] ^ b_x[i]));
    end
    result = {carry[WIDTH], sum};
    flags  = pack_flags(sum, carry[WIDTH-1], carry[WIDTH]);
  end

  // ---- register stage: capture on in_valid, otherwise hold data ----
  logic [WIDTH:0] result_d;
  logic [3:0]     flags_d;
  logic           out_valid_d;
  logic           out_valid_q;

  always_comb begin
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      result_d = result;
      flags_d  = flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_subtractor.sv
// -----------------------------------------------------------------------------
// tb_adder_subtractor
//   Directed and random stimulus against an arithmetic reference model.
//   Expected registered responses are queued at issue time and consumed by an
//   independent monitor whenever the DUT presents out_valid.
// -----------------------------------------------------------------------------
module tb_adder_subtractor;

  localparam int W = 4;

  typedef struct {
    logic [W:0] r;
    logic [3:0] f;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         M;
  logic         in_valid;
  logic [W:0]   result;
  logic [W:0]   result_q;
  logic         out_valid;
  logic [3:0]   flags_q;

  adder_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .M         (M),
    .in_valid  (in_valid),
    .result    (result),
    .result_q  (result_q),
    .out_valid (out_valid),
    .flags_q   (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  exp_t       sb_q[$];
  logic [W:0] last_r = '0;
  logic [3:0] last_f = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    exp_t e;
    int ua, ub, sa, sb, tot, sres;
    logic [W-1:0] s;
    logic c, ovf;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 2**(W-1)) ? ua - 2**W : ua;
    sb = (ub >= 2**(W-1)) ? ub - 2**W : ub;
    if (!m) begin
      tot  = ua + ub;
      c    = (tot >= 2**W);
      s    = tot[W-1:0];
      sres = sa + sb;
    end else begin
      tot  = ua - ub + 2**W;
      c    = (ua >= ub);
      s    = tot[W-1:0];
      sres = sa - sb;
    end
    ovf = (sres > 2**(W-1) - 1) || (sres < -(2**(W-1)));
    e.r = {c, s};
    e.f = {ovf, s[W-1], (s == '0), c};
    return e;
  endfunction

  // Issue one cycle of stimulus on the falling edge and check the
  // combinational path immediately.
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic m, input logic v);
    exp_t e;
    @(negedge clk);
    A = a; B = b; M = m; in_valid = v;
    #1;
    e = model(a, b, m);
    check("comb_result", 32'(result), 32'(e.r));
    if (v) sb_q.push_back(e);
  endtask

  // Monitor: one edge after capture the DUT must present exactly what was queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      check("out_valid", 32'(out_valid), 32'(sb_q.size() > 0));
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("result_q", 32'(result_q), 32'(e.r));
          check("flags_q", 32'(flags_q), 32'(e.f));
          last_r = e.r;
          last_f = e.f;
        end
      end else begin
        check("result_q_hold", 32'(result_q), 32'(last_r));
        check("flags_q_hold", 32'(flags_q), 32'(last_f));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W:0] r_before;
    rst_n = 1'b0; A = '0; B = '0; M = 1'b0; in_valid = 1'b0;
    #3;
    check("reset_result_q", 32'(result_q), 32'd0);
    check("reset_flags_q", 32'(flags_q), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases from the arithmetic boundaries.
    drive(4'b1101, 4'b0010, 1'b0, 1'b1);
    drive(4'b0000, 4'b1000, 1'b0, 1'b1);
    drive(4'b0101, 4'b0011, 1'b1, 1'b1);
    drive(4'b0011, 4'b0101, 1'b1, 1'b1);
    drive(4'b1000, 4'b0001, 1'b1, 1'b1);
    drive(4'b0111, 4'b0001, 1'b0, 1'b1);
    drive(4'b1111, 4'b1111, 1'b0, 1'b1);
    drive(4'b1010, 4'b1010, 1'b1, 1'b1);
    drive(4'b0000, 4'b0001, 1'b1, 1'b1);

    // in_valid 1,0,1 with changing operands: data must hold in the gap.
    drive(4'b0110, 4'b0011, 1'b0, 1'b1);
    drive(4'b1001, 4'b0100, 1'b1, 1'b0);
    drive(4'b0010, 4'b0111, 1'b1, 1'b1);

    // Asynchronous reset between edges while out_valid is high; the
    // capture pending for the next edge is discarded.
    @(negedge clk);
    A = 4'b1100; B = 4'b0101; M = 1'b0; in_valid = 1'b1;
    #1;
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    r_before = result;
    #1;
    rst_n = 1'b0;
    last_r = '0;
    last_f = '0;
    #1;
    check("async_result_q", 32'(result_q), 32'd0);
    check("async_flags_q", 32'(flags_q), 32'd0);
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("comb_during_reset", 32'(result), 32'(r_before));
    check("comb_reset_model", 32'(result), 32'(model(4'b1100, 4'b0101, 1'b0).r));
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Random traffic with random in_valid gaps.
    for (int i = 0; i < 300; i++) begin
      drive(W'($urandom_range(0, 2**W - 1)), W'($urandom_range(0, 2**W - 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
    end

    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
